// File: rtl/dec_onehot_seq.sv
// Registered binary-to-one-hot decoder with a command engine for load, clear,
// single-step and inclusive range scans (one output per cycle, wrap-around allowed).
module dec_onehot_seq #(
    parameter int N = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_op,
    input  logic [N-1:0]       cmd_bin,
    input  logic [N-1:0]       cmd_last,
    output logic [(2**N)-1:0]  onehot,
    output logic [N-1:0]       index,
    output logic               active,
    output logic               busy,
    output logic               done
);

    localparam int W = 2**N;

    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_SCAN  = 2'b01;
    localparam logic [1:0] OP_CLEAR = 2'b10;
    localparam logic [1:0] OP_STEP  = 2'b11;

    typedef enum logic {S_IDLE, S_SCAN} state_t;

    state_t         r_state;
    state_t         w_state_next;
    logic [N-1:0]   r_index;
    logic [N-1:0]   w_index_next;
    logic [N-1:0]   w_index_inc;
    logic [N-1:0]   r_last;
    logic [N-1:0]   w_last_next;
    logic           r_active;
    logic           w_active_next;
    logic           r_done;
    logic           w_done_next;
    logic           w_fire;
    logic [W-1:0]   r_onehot;
    logic [W-1:0]   w_onehot_next;

    assign w_fire      = cmd_valid & cmd_ready;
    assign w_index_inc = r_index + N'(1);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        if (en) begin
            case (r_state)
                S_IDLE: begin
                    if (w_fire && cmd_op == OP_SCAN && cmd_bin != cmd_last) begin
                        w_state_next = S_SCAN;
                    end
                end
                S_SCAN: begin
                    if (w_index_inc == r_last) begin
                        w_state_next = S_IDLE;
                    end
                end
                default: w_state_next = S_IDLE;
            endcase
        end
    end

    // FSM outputs
    always_comb begin
        cmd_ready = ~rst & en & (r_state == S_IDLE);
        busy      = (r_state == S_SCAN);
    end

    // Datapath next values; with en low everything, including a pending done, holds.
    always_comb begin
        w_index_next  = r_index;
        w_active_next = r_active;
        w_last_next   = r_last;
        w_done_next   = r_done;
        if (en) begin
            w_done_next = 1'b0;
            if (r_state == S_SCAN) begin
                w_index_next = w_index_inc;
                if (w_index_inc == r_last) begin
                    w_done_next = 1'b1;
                end
            end else if (w_fire) begin
                case (cmd_op)
                    OP_LOAD: begin
                        w_index_next  = cmd_bin;
                        w_active_next = 1'b1;
                    end
                    OP_SCAN: begin
                        w_index_next  = cmd_bin;
                        w_active_next = 1'b1;
                        w_last_next   = cmd_last;
                        w_done_next   = (cmd_bin == cmd_last);
                    end
                    OP_CLEAR: begin
                        w_index_next  = '0;
                        w_active_next = 1'b0;
                    end
                    OP_STEP: begin
                        w_index_next  = r_active ? w_index_inc : '0;
                        w_active_next = 1'b1;
                    end
                    default: begin
                        w_index_next  = r_index;
                    end
                endcase
            end
        end
    end

    // Decode of the next index so the one-hot register always matches index/active.
    generate
        for (genvar gi = 0; gi < W; gi++) begin : g_dec
            assign w_onehot_next[gi] = w_active_next && (w_index_next == N'(gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_index  <= '0;
            r_active <= 1'b0;
            r_last   <= '0;
            r_done   <= 1'b0;
            r_onehot <= '0;
        end else begin
            r_index  <= w_index_next;
            r_active <= w_active_next;
            r_last   <= w_last_next;
            r_done   <= w_done_next;
            r_onehot <= w_onehot_next;
        end
    end

    assign onehot = r_onehot;
    assign index  = r_index;
    assign active = r_active;
    assign done   = r_done;

endmodule

// File: tb/tb_dec_onehot_seq.sv
// Directed bench for dec_onehot_seq: N=4 command sequences plus N=2/N=6 decode sweeps.
module tb_dec_onehot_seq;

    localparam logic [1:0] LOAD  = 2'b00;
    localparam logic [1:0] SCAN  = 2'b01;
    localparam logic [1:0] CLEAR = 2'b10;
    localparam logic [1:0] STEP  = 2'b11;

    logic clk = 1'b0;
    logic rst, en;
    always #5 clk = ~clk;

    // N=4 instance
    logic        valid4, rdy4, act4, busy4, done4;
    logic [1:0]  op4;
    logic [3:0]  bin4, last4, idx4;
    logic [15:0] oh4;

    // N=2 instance
    logic        valid2, rdy2, act2, busy2, done2;
    logic [1:0]  op2, bin2, last2, idx2;
    logic [3:0]  oh2;

    // N=6 instance
    logic        valid6, rdy6, act6, busy6, done6;
    logic [1:0]  op6;
    logic [5:0]  bin6, last6, idx6;
    logic [63:0] oh6;

    dec_onehot_seq #(.N(4)) u_dut4 (
        .clk(clk), .rst(rst), .en(en), .cmd_valid(valid4), .cmd_ready(rdy4),
        .cmd_op(op4), .cmd_bin(bin4), .cmd_last(last4), .onehot(oh4),
        .index(idx4), .active(act4), .busy(busy4), .done(done4)
    );

    dec_onehot_seq #(.N(2)) u_dut2 (
        .clk(clk), .rst(rst), .en(en), .cmd_valid(valid2), .cmd_ready(rdy2),
        .cmd_op(op2), .cmd_bin(bin2), .cmd_last(last2), .onehot(oh2),
        .index(idx2), .active(act2), .busy(busy2), .done(done2)
    );

    dec_onehot_seq #(.N(6)) u_dut6 (
        .clk(clk), .rst(rst), .en(en), .cmd_valid(valid6), .cmd_ready(rdy6),
        .cmd_op(op6), .cmd_bin(bin6), .cmd_last(last6), .onehot(oh6),
        .index(idx6), .active(act6), .busy(busy6), .done(done6)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic expect4(input string tag, input logic [15:0] oh, input logic [3:0] idx,
                           input logic act, input logic bsy, input logic dn);
        check({tag, ".onehot"}, 64'(oh4), 64'(oh));
        check({tag, ".index"},  64'(idx4), 64'(idx));
        check({tag, ".active"}, 64'(act4), 64'(act));
        check({tag, ".busy"},   64'(busy4), 64'(bsy));
        check({tag, ".done"},   64'(done4), 64'(dn));
        $display("N4 %-10s onehot=%04h index=%0d active=%0b busy=%0b done=%0b ready=%0b",
                 tag, oh4, idx4, act4, busy4, done4, rdy4);
    endtask

    task automatic issue4(input logic [1:0] op, input logic [3:0] bin, input logic [3:0] last);
        valid4 = 1'b1; op4 = op; bin4 = bin; last4 = last;
        tick;
        valid4 = 1'b0;
    endtask

    initial begin
        logic [3:0] wi;
        rst = 1'b1; en = 1'b1;
        valid4 = 0; op4 = 0; bin4 = 0; last4 = 0;
        valid2 = 0; op2 = 0; bin2 = 0; last2 = 0;
        valid6 = 0; op6 = 0; bin6 = 0; last6 = 0;
        tick; tick;

        check("rst_ready", 64'(rdy4), 64'(0));
        expect4("reset", 16'h0000, 4'd0, 0, 0, 0);
        rst = 1'b0;
        #1;
        check("idle_ready", 64'(rdy4), 64'(1));

        issue4(LOAD, 4'd9, 4'd0);
        expect4("load9", 16'h0200, 4'd9, 1, 0, 0);
        issue4(CLEAR, 4'd0, 4'd0);
        expect4("clear", 16'h0000, 4'd0, 0, 0, 0);

        // Scan 3..6
        issue4(SCAN, 4'd3, 4'd6);
        for (int k = 0; k < 4; k++) begin
            wi = 4'(3 + k);
            expect4("scan3_6", 16'(1) << wi, wi, 1, k < 3, k == 3);
            check("scan3_6.ready", 64'(rdy4), 64'(k == 3));
            if (k < 3) tick;
        end
        tick;
        expect4("hold6", 16'h0040, 4'd6, 1, 0, 0);

        // Wrap scan 14..1, then back-to-back LOAD in the done cycle
        issue4(SCAN, 4'd14, 4'd1);
        for (int k = 0; k < 4; k++) begin
            wi = 4'(14 + k);
            expect4("wrap14_1", 16'(1) << wi, wi, 1, k < 3, k == 3);
            if (k < 3) tick;
        end
        issue4(LOAD, 4'd15, 4'd0);
        expect4("load15", 16'h8000, 4'd15, 1, 0, 0);
        issue4(STEP, 4'd0, 4'd0);
        expect4("step_wrap", 16'h0001, 4'd0, 1, 0, 0);
        issue4(CLEAR, 4'd0, 4'd0);
        issue4(STEP, 4'd7, 4'd0);
        expect4("step_inact", 16'h0001, 4'd0, 1, 0, 0);
        issue4(STEP, 4'd7, 4'd0);
        expect4("step1", 16'h0002, 4'd1, 1, 0, 0);

        // Scan 0..7 with en paused at index 2 and a stray CLEAR held on cmd_valid
        issue4(SCAN, 4'd0, 4'd7);
        valid4 = 1'b1; op4 = CLEAR;
        tick; tick;
        expect4("pre_pause", 16'h0004, 4'd2, 1, 1, 0);
        en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick;
            expect4("paused", 16'h0004, 4'd2, 1, 1, 0);
            check("paused.ready", 64'(rdy4), 64'(0));
        end
        en = 1'b1;
        for (int i = 3; i <= 7; i++) begin
            tick;
            wi = 4'(i);
            expect4("resume", 16'(1) << wi, wi, 1, i < 7, i == 7);
            if (i == 5) valid4 = 1'b0;
        end
        en = 1'b0;
        tick;
        expect4("done_frz", 16'h0080, 4'd7, 1, 0, 1);
        en = 1'b1;
        tick;
        expect4("done_clr", 16'h0080, 4'd7, 1, 0, 0);

        // Reset mid-scan
        issue4(SCAN, 4'd0, 4'd10);
        repeat (4) tick;
        expect4("at4", 16'h0010, 4'd4, 1, 1, 0);
        rst = 1'b1;
        tick;
        expect4("mid_rst", 16'h0000, 4'd0, 0, 0, 0);
        rst = 1'b0;
        issue4(LOAD, 4'd5, 4'd0);
        expect4("load5", 16'h0020, 4'd5, 1, 0, 0);

        // Single-beat scan
        issue4(SCAN, 4'd9, 4'd9);
        expect4("single", 16'h0200, 4'd9, 1, 0, 1);
        check("single.ready", 64'(rdy4), 64'(1));
        tick;
        expect4("single_end", 16'h0200, 4'd9, 1, 0, 0);

        // N=2 exhaustive decode
        for (int i = 0; i < 4; i++) begin
            valid2 = 1'b1; op2 = LOAD; bin2 = 2'(i);
            tick;
            check("n2_onehot", 64'(oh2), 64'(4'(1) << i));
            check("n2_index", 64'(idx2), 64'(i));
            $display("N2 load %0d onehot=%01h index=%0d", i, oh2, idx2);
        end
        op2 = SCAN; bin2 = 2'd2; last2 = 2'd2;
        tick;
        valid2 = 1'b0;
        check("n2_single.done", 64'(done2), 64'(1));
        check("n2_single.busy", 64'(busy2), 64'(0));
        check("n2_single.onehot", 64'(oh2), 64'(4'h4));
        $display("N2 scan 2..2 onehot=%01h done=%0b busy=%0b", oh2, done2, busy2);

        // N=6 exhaustive decode
        for (int i = 0; i < 64; i++) begin
            valid6 = 1'b1; op6 = LOAD; bin6 = 6'(i);
            tick;
            check("n6_onehot", oh6, 64'(1) << i);
            check("n6_index", 64'(idx6), 64'(i));
            $display("N6 load %0d onehot=%016h index=%0d", i, oh6, idx6);
        end
        op6 = SCAN; bin6 = 6'd63; last6 = 6'd63;
        tick;
        valid6 = 1'b0;
        check("n6_single.done", 64'(done6), 64'(1));
        check("n6_single.busy", 64'(busy6), 64'(0));
        check("n6_single.onehot", oh6, 64'h8000_0000_0000_0000);
        $display("N6 scan 63..63 onehot=%016h done=%0b busy=%0b", oh6, done6, busy6);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
